countdown_display: RTL

COUNTDOWN_DISPLAY -- requirements
Module: countdown_display

---
 rtl/countdown_pkg.sv | 25 ++
 rtl/seg7_decoder.sv | 26 ++
 rtl/countdown_display.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared segment constants and alarm state encoding for the countdown display.
// Segment words are active-low, ordered {g,f,e,d,c,b,a}.
package countdown_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BEEP_ON  = 2'd1,
      BEEP_OFF = 2'd2,
      DONE     = 2'd3
   } alarm_state_e;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 show a dash.
module seg7_decoder
   import countdown_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/countdown_display.sv
// Two-digit countdown display with leading-zero blanking and an expiry buzzer pattern.
// Optional warning blink of low values is enabled by defining COUNTDOWN_BLINK_EN.
module countdown_display
   import countdown_pkg::*;
#(
   parameter int unsigned BLINK_DIV       = 25000000,
   parameter int unsigned BEEP_ON_CYCLES  = 12500000,
   parameter int unsigned BEEP_OFF_CYCLES = 12500000,
   parameter int unsigned BEEP_COUNT      = 3,
   parameter logic [7:0]  WARN_LEVEL      = 8'h05
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] time_h,
   input  logic [3:0] time_l,
   input  logic       expired,
   output logic [6:0] hex1,
   output logic [6:0] hex0,
   output logic       buzzer,
   output logic       alarm_done
);

   localparam int unsigned CYC_MAX = (BEEP_ON_CYCLES > BEEP_OFF_CYCLES) ? BEEP_ON_CYCLES
                                                                         : BEEP_OFF_CYCLES;
   localparam int CYC_W   = $clog2(CYC_MAX) + 1;
   localparam int PULSE_W = $clog2(BEEP_COUNT) + 1;
   localparam logic [CYC_W-1:0]   ON_LAST    = CYC_W'(BEEP_ON_CYCLES - 1);
   localparam logic [CYC_W-1:0]   OFF_LAST   = CYC_W'(BEEP_OFF_CYCLES - 1);
   localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(BEEP_COUNT - 1);

   if (BLINK_DIV == 0 || BEEP_ON_CYCLES == 0 || BEEP_OFF_CYCLES == 0 || BEEP_COUNT == 0 ||
       WARN_LEVEL[3:0] > 4'd9 || WARN_LEVEL[7:4] > 4'd9) begin : g_param_check
      $error("countdown_display: invalid parameter value");
   end

   logic [3:0]         timeH_q, timeL_q;
   logic               expired_q, expiredPrev_q;
   logic [6:0]         hex1_q, hex0_q, hex1_d, hex0_d;
   logic [6:0]         tensSeg, unitsSeg;
   logic               blankAll;
   alarm_state_e       state_q;
   logic [CYC_W-1:0]   cycleCnt_q;
   logic [PULSE_W-1:0] pulseCnt_q;
   logic               buzzer_q, alarmDone_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         timeH_q       <= '0;
         timeL_q       <= '0;
         expired_q     <= 1'b0;
         expiredPrev_q <= 1'b0;
      end else begin
         timeH_q       <= time_h;
         timeL_q       <= time_l;
         expired_q     <= expired;
         expiredPrev_q <= expired_q;
      end
   end

   seg7_decoder u_tens  (.bcd_i(timeH_q), .seg_o(tensSeg));
   seg7_decoder u_units (.bcd_i(timeL_q), .seg_o(unitsSeg));

`ifdef COUNTDOWN_BLINK_EN
   localparam int BLINK_W = $clog2(BLINK_DIV) + 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   logic [BLINK_W-1:0] blinkCnt_q;
   logic               blinkPhase_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         blinkCnt_q   <= '0;
         blinkPhase_q <= 1'b0;
      end else if (blinkCnt_q == BLINK_LAST) begin
         blinkCnt_q   <= '0;
         blinkPhase_q <= ~blinkPhase_q;
      end else begin
         blinkCnt_q <= blinkCnt_q + 1'b1;
      end
   end

   // BCD bytes order the same as their decimal values, so a plain compare works.
   always_comb begin
      blankAll = blinkPhase_q && !expired_q && ({timeH_q, timeL_q} != 8'h00) &&
                 ({timeH_q, timeL_q} <= WARN_LEVEL);
   end
`else
   assign blankAll = 1'b0;
`endif

   always_comb begin
      hex1_d = tensSeg;
      hex0_d = unitsSeg;
      if (timeH_q == 4'd0) hex1_d = SEG_BLANK;
      if (blankAll) begin
         hex1_d = SEG_BLANK;
         hex0_d = SEG_BLANK;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hex1_q <= SEG_BLANK;
         hex0_q <= SEG_BLANK;
      end else begin
         hex1_q <= hex1_d;
         hex0_q <= hex0_d;
      end
   end

   // Losing expiry mid-pattern drops straight back to IDLE with everything cleared.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cycleCnt_q   <= '0;
         pulseCnt_q   <= '0;
         buzzer_q     <= 1'b0;
         alarmDone_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               cycleCnt_q  <= '0;
               pulseCnt_q  <= '0;
               buzzer_q    <= 1'b0;
               alarmDone_q <= 1'b0;
               if (expired_q && !expiredPrev_q) begin
                  state_q  <= BEEP_ON;
                  buzzer_q <= 1'b1;
               end
            end
            BEEP_ON: begin
               if (!expired_q) begin
                  state_q    <= IDLE;
                  cycleCnt_q <= '0;
                  pulseCnt_q <= '0;
                  buzzer_q   <= 1'b0;
               end else if (cycleCnt_q == ON_LAST) begin
                  state_q    <= BEEP_OFF;
                  cycleCnt_q <= '0;
                  buzzer_q   <= 1'b0;
               end else begin
                  cycleCnt_q <= cycleCnt_q + 1'b1;
               end
            end
            BEEP_OFF: begin
               if (!expired_q) begin
                  state_q    <= IDLE;
                  cycleCnt_q <= '0;
                  pulseCnt_q <= '0;
                  buzzer_q   <= 1'b0;
               end else if (cycleCnt_q == OFF_LAST) begin
                  cycleCnt_q <= '0;
                  pulseCnt_q <= pulseCnt_q + 1'b1;
                  if (pulseCnt_q == PULSE_LAST) begin
                     state_q     <= DONE;
                     alarmDone_q <= 1'b1;
                  end else begin
                     state_q  <= BEEP_ON;
                     buzzer_q <= 1'b1;
                  end
               end else begin
                  cycleCnt_q <= cycleCnt_q + 1'b1;
               end
            end
            DONE: begin
               buzzer_q    <= 1'b0;
               alarmDone_q <= 1'b1;
               if (!expired_q) begin
                  state_q     <= IDLE;
                  alarmDone_q <= 1'b0;
                  pulseCnt_q  <= '0;
                  cycleCnt_q  <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign hex1       = hex1_q;
   assign hex0       = hex0_q;
   assign buzzer     = buzzer_q;
   assign alarm_done = alarmDone_q;

endmodule
